// File: rtl/dec_scan_pkg.sv
// Shared types and sizing helpers for the decoder scan sequencer.
package dec_scan_pkg;

  localparam int unsigned SEL_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHOW  = 2'd1,
    ST_BLANK = 2'd2
  } scan_state_t;

  // Wide enough to hold the longer of the two phase lengths.
  function automatic int unsigned cnt_w(input int unsigned dwell, input int unsigned blank);
    int unsigned m;
    m = (dwell > blank) ? dwell : blank;
    return $clog2(m + 1);
  endfunction

endpackage

// File: rtl/dec_scan_ctrl_if.sv
// Control/status bundle between the scan sequencer and its controller.
interface dec_scan_ctrl_if;
  import dec_scan_pkg::*;

  logic             start;
  logic             stop;
  logic [SEL_W-1:0] sel;
  logic             en;
  logic             busy;
  logic             frame_done;

  modport master (output start, output stop,
                  input  sel, input en, input busy, input frame_done);
  modport slave  (input  start, input stop,
                  output sel, output en, output busy, output frame_done);
endinterface

// File: rtl/dec_scan_ctrl_dwell_cnt.sv
// Loadable down-counter; zero flags the final cycle of the loaded phase.
module dwell_cnt #(
  parameter int unsigned W = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         zero
);

  logic [W-1:0] cnt_q, cnt_d;
  logic         zero_q, zero_d;

  // zero is precomputed so it is registered alongside the count.
  always_comb begin
    cnt_d  = cnt_q;
    zero_d = zero_q;
    if (load) begin
      cnt_d  = value;
      zero_d = (value == '0);
    end else if (cnt_q != '0) begin
      cnt_d  = cnt_q - W'(1);
      zero_d = (cnt_q == W'(1));
    end else begin
      zero_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q  <= '0;
      zero_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      zero_q <= zero_d;
    end
  end

  assign zero = zero_q;

endmodule

// File: rtl/dec_scan_ctrl.sv
// Scan sequencer: steps a decoder select through N_DIGIT digits with
// programmable dwell and blanking, pulsing frame_done at each frame end.
module dec_scan_ctrl
  import dec_scan_pkg::*;
#(
  parameter int unsigned DWELL   = 4,
  parameter int unsigned BLANK   = 1,
  parameter int unsigned N_DIGIT = 8
) (
  input  logic           clk,
  input  logic           rst_n,
  dec_scan_ctrl_if.slave bus
);

  localparam int unsigned      CW       = cnt_w(DWELL, BLANK);
  localparam logic [CW-1:0]    DWELL_LD = CW'(DWELL - 1);
  localparam logic [CW-1:0]    BLANK_LD = (BLANK > 0) ? CW'(BLANK - 1) : '0;
  localparam logic [SEL_W-1:0] LAST_SEL = SEL_W'(N_DIGIT - 1);

  scan_state_t      state_q, state_d;
  logic [SEL_W-1:0] sel_q, sel_d;
  logic             en_q, en_d;
  logic             busy_q, busy_d;
  logic             frame_done_q, frame_done_d;
  logic             pend_q, pend_d;

  logic             adv;
  logic             cnt_load;
  logic [CW-1:0]    cnt_value;
  logic             cnt_zero;

  dwell_cnt #(.W(CW)) u_dwell_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .load  (cnt_load),
    .value (cnt_value),
    .zero  (cnt_zero)
  );

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    pend_d       = pend_q;
    frame_done_d = 1'b0;
    adv          = 1'b0;
    cnt_load     = 1'b0;
    cnt_value    = DWELL_LD;

    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          state_d  = ST_SHOW;
          sel_d    = '0;
          pend_d   = bus.stop;
          cnt_load = 1'b1;
        end
      end
      ST_SHOW: begin
        pend_d = pend_q | bus.stop;
        if (cnt_zero) begin
          if (BLANK > 0) begin
            state_d   = ST_BLANK;
            cnt_load  = 1'b1;
            cnt_value = BLANK_LD;
          end else begin
            adv = 1'b1;
          end
        end
      end
      ST_BLANK: begin
        pend_d = pend_q | bus.stop;
        if (cnt_zero) adv = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    // Digit advance; the last digit closes the frame and honours a pending stop.
    if (adv) begin
      if (sel_q < LAST_SEL) begin
        sel_d    = sel_q + SEL_W'(1);
        state_d  = ST_SHOW;
        cnt_load = 1'b1;
      end else begin
        frame_done_d = 1'b1;
        sel_d        = '0;
        if (pend_d) begin
          state_d = ST_IDLE;
          pend_d  = 1'b0;
        end else begin
          state_d  = ST_SHOW;
          cnt_load = 1'b1;
        end
      end
    end

    en_d   = (state_d == ST_SHOW);
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      sel_q        <= '0;
      en_q         <= 1'b0;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      pend_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      en_q         <= en_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      pend_q       <= pend_d;
    end
  end

  assign bus.sel        = sel_q;
  assign bus.en         = en_q;
  assign bus.busy       = busy_q;
  assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_dec_scan_ctrl.sv
// Bench for dec_scan_ctrl: two configurations (4/1/8 and 4/0/3) driven in
// lockstep and compared every cycle against an arithmetic frame model.
module tb_dec_scan_ctrl;

  localparam int A_D = 4, A_B = 1, A_N = 8;
  localparam int B_D = 4, B_B = 0, B_N = 3;

  logic clk   = 1'b0;
  logic rst_n = 1'b1;
  logic start = 1'b0;
  logic stop  = 1'b0;

  int n_assert = 0;
  int n_fail   = 0;
  int cyc      = 0;

  dec_scan_ctrl_if ifa ();
  dec_scan_ctrl_if ifb ();

  assign ifa.start = start;
  assign ifa.stop  = stop;
  assign ifb.start = start;
  assign ifb.stop  = stop;

  dec_scan_ctrl #(.DWELL(A_D), .BLANK(A_B), .N_DIGIT(A_N)) u_dut_a (
    .clk (clk), .rst_n (rst_n), .bus (ifa)
  );
  dec_scan_ctrl #(.DWELL(B_D), .BLANK(B_B), .N_DIGIT(B_N)) u_dut_b (
    .clk (clk), .rst_n (rst_n), .bus (ifb)
  );

  logic [2:0] o_sel  [2];
  logic       o_en   [2];
  logic       o_busy [2];
  logic       o_fd   [2];
  assign o_sel[0] = ifa.sel;  assign o_en[0] = ifa.en;
  assign o_busy[0] = ifa.busy; assign o_fd[0] = ifa.frame_done;
  assign o_sel[1] = ifb.sel;  assign o_en[1] = ifb.en;
  assign o_busy[1] = ifb.busy; assign o_fd[1] = ifb.frame_done;

  initial forever #5 clk = ~clk;

  // Model: while scanning, p counts cycles since the scan began; every output
  // follows from p by frame/digit arithmetic.
  bit m_busy [2];
  int m_p    [2];
  bit m_pend [2];
  bit m_fdi  [2];

  function automatic int pd(input int i); return (i == 0) ? A_D : B_D; endfunction
  function automatic int pb(input int i); return (i == 0) ? A_B : B_B; endfunction
  function automatic int pn(input int i); return (i == 0) ? A_N : B_N; endfunction

  task automatic m_step(input int i, input bit st, input bit sp);
    int fl;
    fl = pn(i) * (pd(i) + pb(i));
    if (!m_busy[i]) begin
      m_fdi[i] = 1'b0;
      if (st) begin
        m_busy[i] = 1'b1;
        m_p[i]    = 0;
        m_pend[i] = sp;
      end
    end else begin
      m_pend[i] = m_pend[i] | sp;
      if (((m_p[i] + 1) % fl == 0) && m_pend[i]) begin
        m_busy[i] = 1'b0;
        m_fdi[i]  = 1'b1;
        m_pend[i] = 1'b0;
      end else begin
        m_p[i] = m_p[i] + 1;
      end
    end
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_assert++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s @%0t: got %0d expected %0d", nm, $time, act, exp);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_busy[i] = 1'b0; m_p[i] = 0; m_pend[i] = 1'b0; m_fdi[i] = 1'b0;
      end
    end else begin
      m_step(0, start, stop);
      m_step(1, start, stop);
    end
  end

  initial forever begin
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      int fl, f, es, ee, eb, ef;
      fl = pn(i) * (pd(i) + pb(i));
      if (m_busy[i]) begin
        f  = m_p[i] % fl;
        es = f / (pd(i) + pb(i));
        ee = ((f % (pd(i) + pb(i))) < pd(i)) ? 1 : 0;
        eb = 1;
        ef = (m_p[i] > 0 && f == 0) ? 1 : 0;
      end else begin
        es = 0; ee = 0; eb = 0; ef = m_fdi[i] ? 1 : 0;
      end
      chk((i == 0) ? "a_sel" : "b_sel", 32'(o_sel[i]), 32'(es));
      chk((i == 0) ? "a_en" : "b_en", 32'(o_en[i]), 32'(ee));
      chk((i == 0) ? "a_busy" : "b_busy", 32'(o_busy[i]), 32'(eb));
      chk((i == 0) ? "a_frame_done" : "b_frame_done", 32'(o_fd[i]), 32'(ef));
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic adv(input int k);
    while (cyc < k) begin
      step();
      cyc++;
    end
  endtask

  initial begin
    // Reset held with start high: everything stays at reset values.
    #1 rst_n = 1'b0;
    start = 1'b1;
    repeat (3) step();
    chk("rst_a_sel", 32'(ifa.sel), 0);   chk("rst_a_en", 32'(ifa.en), 0);
    chk("rst_a_busy", 32'(ifa.busy), 0); chk("rst_a_fd", 32'(ifa.frame_done), 0);
    chk("rst_b_en", 32'(ifb.en), 0);     chk("rst_b_busy", 32'(ifb.busy), 0);
    rst_n = 1'b1;
    start = 1'b0;
    step(); step();
    stop = 1'b1; step(); stop = 1'b0; step();
    chk("idle_stop_busy", 32'(ifa.busy), 0);

    // Free-running frame, then a stop request mid-frame.
    start = 1'b1; step(); start = 1'b0; cyc = 1;
    chk("a_c1_en", 32'(ifa.en), 1); chk("a_c1_busy", 32'(ifa.busy), 1);
    adv(5);  chk("a_c5_en", 32'(ifa.en), 0);  chk("a_c5_sel", 32'(ifa.sel), 0);
    adv(6);  chk("a_c6_sel", 32'(ifa.sel), 1); chk("a_c6_en", 32'(ifa.en), 1);
    adv(12); chk("b_c12_fd", 32'(ifb.frame_done), 0); chk("b_c12_sel", 32'(ifb.sel), 2);
    adv(13); chk("b_c13_fd", 32'(ifb.frame_done), 1); chk("b_c13_sel", 32'(ifb.sel), 0);
    chk("b_c13_en", 32'(ifb.en), 1);
    adv(25); chk("b_c25_fd", 32'(ifb.frame_done), 1);
    adv(37); chk("b_c37_fd", 32'(ifb.frame_done), 1);
    adv(40); chk("a_c40_sel", 32'(ifa.sel), 7); chk("a_c40_en", 32'(ifa.en), 0);
    chk("a_c40_fd", 32'(ifa.frame_done), 0);
    adv(41); chk("a_c41_fd", 32'(ifa.frame_done), 1); chk("a_c41_sel", 32'(ifa.sel), 0);
    chk("a_c41_en", 32'(ifa.en), 1); chk("a_c41_busy", 32'(ifa.busy), 1);
    adv(50); stop = 1'b1; adv(51); stop = 1'b0;
    adv(80); chk("a_c80_busy", 32'(ifa.busy), 1);
    adv(81); chk("a_c81_fd", 32'(ifa.frame_done), 1); chk("a_c81_busy", 32'(ifa.busy), 0);
    chk("a_c81_en", 32'(ifa.en), 0);
    adv(90); chk("a_c90_busy", 32'(ifa.busy), 0);

    // start+stop together: one frame only, start while busy ignored.
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0; cyc = 1;
    adv(20); start = 1'b1; adv(21); start = 1'b0;
    adv(40); chk("ss_c40_busy", 32'(ifa.busy), 1);
    adv(41); chk("ss_c41_fd", 32'(ifa.frame_done), 1); chk("ss_c41_busy", 32'(ifa.busy), 0);
    adv(50); chk("ss_c50_busy", 32'(ifa.busy), 0);
    stop = 1'b1; step(); stop = 1'b0;
    repeat (30) step();

    // Asynchronous reset mid-SHOW.
    start = 1'b1; step(); start = 1'b0; cyc = 1;
    adv(13); chk("ar_pre_en", 32'(ifa.en), 1);
    #1 rst_n = 1'b0;
    #1;
    chk("ar_a_en", 32'(ifa.en), 0);   chk("ar_a_busy", 32'(ifa.busy), 0);
    chk("ar_b_en", 32'(ifb.en), 0);   chk("ar_b_busy", 32'(ifb.busy), 0);
    step(); step();
    rst_n = 1'b1;
    repeat (5) step();
    chk("ar_post_busy", 32'(ifa.busy), 0); chk("ar_post_sel", 32'(ifa.sel), 0);
    chk("ar_post_b_busy", 32'(ifb.busy), 0);

    // Randomised start/stop/reset traffic against the model.
    repeat (3000) begin
      start = ($urandom_range(0, 19) == 0);
      stop  = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 499) == 0) begin
        rst_n = 1'b0;
        #1;
        chk("rnd_rst_a_busy", 32'(ifa.busy), 0);
        chk("rnd_rst_b_en", 32'(ifb.en), 0);
      end else begin
        rst_n = 1'b1;
      end
      step();
    end
    rst_n = 1'b1;
    start = 1'b0;
    stop  = 1'b0;
    step(); step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
